// File: rtl/coord_link_pkg.sv
`default_nettype none
// ============================================================================
// Module      : coord_link_pkg
// Description : Shared definitions for the ESP32 coordinate link.
//               Holds the frame delimiters, the frame-parser state encodings
//               and the frame checksum function.
// Revision    : 1.0 - initial release
// ============================================================================
package coord_link_pkg;

    // Frame delimiters: HDR, LAT, LON, CHK, TRL
    localparam logic [7:0] FRAME_HDR = 8'hA5;
    localparam logic [7:0] FRAME_TRL = 8'h5A;

    // Frame-parser state encodings
    localparam logic [2:0] ST_WAIT_HDR = 3'd0;
    localparam logic [2:0] ST_GET_LAT  = 3'd1;
    localparam logic [2:0] ST_GET_LON  = 3'd2;
    localparam logic [2:0] ST_GET_CHK  = 3'd3;
    localparam logic [2:0] ST_GET_TRL  = 3'd4;

    // The checksum folds in the header so that an all-zero payload
    // does not yield an all-zero checksum.
    function automatic logic [7:0] frame_checksum(input logic [7:0] lat,
                                                  input logic [7:0] lon);
        return FRAME_HDR ^ lat ^ lon;
    endfunction

endpackage : coord_link_pkg
`default_nettype wire

// File: rtl/uart_rx_byte.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx_byte
// Description : 8N1 UART byte receiver with a 2-FF input synchronizer.
//               Emits a 1-cycle byte_valid_o with the received byte, or a
//               1-cycle byte_err_o when the stop bit is sampled low.
// Ports       : clk          - system clock
//               reset        - synchronous, active-low reset
//               rx_i         - asynchronous UART line, idle high
//               byte_o       - last received byte (valid with byte_valid_o)
//               byte_valid_o - 1-cycle pulse, byte received with good stop
//               byte_err_o   - 1-cycle pulse, stop bit sampled low
// Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_byte #(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx_i,
    output logic [7:0] byte_o,
    output logic       byte_valid_o,
    output logic       byte_err_o
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] C_BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] C_HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);

    localparam logic [2:0] RX_IDLE  = 3'd0;
    localparam logic [2:0] RX_START = 3'd1;
    localparam logic [2:0] RX_DATA  = 3'd2;
    localparam logic [2:0] RX_STOP  = 3'd3;
    // Entered after a framing error: the line must return high before a
    // new start bit is looked for.
    localparam logic [2:0] RX_BREAK = 3'd4;

    logic             rx_meta_q, rx_sync_q, rx_prev_q;
    logic [2:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       bit_q, bit_d;
    logic [7:0]       shift_q, shift_d;
    logic [7:0]       byte_q, byte_d;
    logic             valid_q, valid_d;
    logic             err_q, err_d;
    logic             fall;

    // Synchronizer flops reset high so that reset never looks like a start bit
    always_ff @(posedge clk) begin
        if (!reset) begin
            rx_meta_q <= 1'b1;
            rx_sync_q <= 1'b1;
            rx_prev_q <= 1'b1;
        end else begin
            rx_meta_q <= rx_i;
            rx_sync_q <= rx_meta_q;
            rx_prev_q <= rx_sync_q;
        end
    end

    assign fall = rx_prev_q & ~rx_sync_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        byte_d  = byte_q;
        valid_d = 1'b0;
        err_d   = 1'b0;
        case (state_q)
            RX_IDLE: begin
                if (fall) begin
                    state_d = RX_START;
                    cnt_d   = '0;
                end
            end
            RX_START: begin
                if (cnt_q == C_HALF_LAST) begin
                    cnt_d = '0;
                    bit_d = 3'd0;
                    // A start bit that has already gone high is a glitch
                    state_d = rx_sync_q ? RX_IDLE : RX_DATA;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            RX_DATA: begin
                if (cnt_q == C_BIT_LAST) begin
                    cnt_d   = '0;
                    shift_d = {rx_sync_q, shift_q[7:1]};
                    if (bit_q == 3'd7) begin
                        state_d = RX_STOP;
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            RX_STOP: begin
                if (cnt_q == C_BIT_LAST) begin
                    cnt_d = '0;
                    if (rx_sync_q) begin
                        byte_d  = shift_q;
                        valid_d = 1'b1;
                        state_d = RX_IDLE;
                    end else begin
                        err_d   = 1'b1;
                        state_d = RX_BREAK;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            RX_BREAK: begin
                if (rx_sync_q) begin
                    state_d = RX_IDLE;
                end
            end
            default: state_d = RX_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= RX_IDLE;
            cnt_q   <= '0;
            bit_q   <= 3'd0;
            shift_q <= 8'h00;
            byte_q  <= 8'h00;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            byte_q  <= byte_d;
            valid_q <= valid_d;
            err_q   <= err_d;
        end
    end

    assign byte_o       = byte_q;
    assign byte_valid_o = valid_q;
    assign byte_err_o   = err_q;

endmodule : uart_rx_byte
`default_nettype wire

// File: rtl/uart_coord_receiver.sv
`default_nettype none
// ============================================================================
// Module      : uart_coord_receiver
// Description : Receives A5/LAT/LON/CHK/5A coordinate frames from the ESP32
//               LoRa board, validates them and presents the accepted
//               latitude/longitude bytes plus a sticky ready level to the
//               LCD1602 controller.
// Ports       : clk         - system clock
//               reset       - synchronous, active-low reset
//               rx_i        - asynchronous UART line, idle high
//               latitud     - last accepted latitude byte
//               longitud    - last accepted longitude byte
//               ready_o     - high once the first valid frame was accepted
//               frame_ok_o  - 1-cycle pulse per accepted frame
//               frame_err_o - 1-cycle pulse per rejected frame
// Revision    : 1.0 - initial release
// ============================================================================
module uart_coord_receiver #(
    parameter int CLK_FREQ           = 50_000_000,
    parameter int BAUD               = 115200,
    parameter int CLKS_PER_BIT       = CLK_FREQ / BAUD,
    parameter int FRAME_TIMEOUT_CLKS = 20 * CLKS_PER_BIT * 10
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx_i,
    output logic [7:0] latitud,
    output logic [7:0] longitud,
    output logic       ready_o,
    output logic       frame_ok_o,
    output logic       frame_err_o
);

    import coord_link_pkg::*;

    localparam int TMO_W = $clog2(FRAME_TIMEOUT_CLKS + 1);
    localparam logic [TMO_W-1:0] C_TMO_LIMIT = TMO_W'(FRAME_TIMEOUT_CLKS);

    logic [7:0]       rx_byte;
    logic             rx_valid;
    logic             rx_err;

    logic [2:0]       state_q, state_d;
    logic [7:0]       lat_q, lat_d;
    logic [7:0]       lon_q, lon_d;
    logic [7:0]       chk_q, chk_d;
    logic [TMO_W-1:0] tmo_q, tmo_d;
    logic [7:0]       latitud_q, latitud_d;
    logic [7:0]       longitud_q, longitud_d;
    logic             ready_q, ready_d;
    logic             ok_q, ok_d;
    logic             err_q, err_d;

    uart_rx_byte #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_rx (
        .clk          (clk),
        .reset        (reset),
        .rx_i         (rx_i),
        .byte_o       (rx_byte),
        .byte_valid_o (rx_valid),
        .byte_err_o   (rx_err)
    );

    // Byte events take precedence over the timeout, and at most one of
    // ok_d/err_d is set per cycle, so the two pulses can never overlap.
    always_comb begin
        state_d    = state_q;
        lat_d      = lat_q;
        lon_d      = lon_q;
        chk_d      = chk_q;
        latitud_d  = latitud_q;
        longitud_d = longitud_q;
        ready_d    = ready_q;
        ok_d       = 1'b0;
        err_d      = 1'b0;
        // Saturating idle counter, cleared by every received byte
        tmo_d      = (tmo_q == C_TMO_LIMIT) ? tmo_q : tmo_q + TMO_W'(1);

        if (rx_valid) begin
            tmo_d = '0;
            case (state_q)
                ST_WAIT_HDR: begin
                    if (rx_byte == FRAME_HDR) begin
                        state_d = ST_GET_LAT;
                    end
                end
                ST_GET_LAT: begin
                    lat_d   = rx_byte;
                    state_d = ST_GET_LON;
                end
                ST_GET_LON: begin
                    lon_d   = rx_byte;
                    state_d = ST_GET_CHK;
                end
                ST_GET_CHK: begin
                    chk_d   = rx_byte;
                    state_d = ST_GET_TRL;
                end
                ST_GET_TRL: begin
                    if ((rx_byte == FRAME_TRL) &&
                        (chk_q == frame_checksum(lat_q, lon_q))) begin
                        latitud_d  = lat_q;
                        longitud_d = lon_q;
                        ready_d    = 1'b1;
                        ok_d       = 1'b1;
                    end else begin
                        err_d = 1'b1;
                    end
                    state_d = ST_WAIT_HDR;
                end
                default: state_d = ST_WAIT_HDR;
            endcase
        end else if (rx_err) begin
            // A corrupted byte only matters once a frame has started
            if (state_q != ST_WAIT_HDR) begin
                err_d   = 1'b1;
                state_d = ST_WAIT_HDR;
            end
        end else if ((state_q != ST_WAIT_HDR) && (tmo_q == C_TMO_LIMIT)) begin
            err_d   = 1'b1;
            state_d = ST_WAIT_HDR;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= ST_WAIT_HDR;
            lat_q      <= 8'h00;
            lon_q      <= 8'h00;
            chk_q      <= 8'h00;
            tmo_q      <= '0;
            latitud_q  <= 8'h00;
            longitud_q <= 8'h00;
            ready_q    <= 1'b0;
            ok_q       <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            lat_q      <= lat_d;
            lon_q      <= lon_d;
            chk_q      <= chk_d;
            tmo_q      <= tmo_d;
            latitud_q  <= latitud_d;
            longitud_q <= longitud_d;
            ready_q    <= ready_d;
            ok_q       <= ok_d;
            err_q      <= err_d;
        end
    end

    assign latitud     = latitud_q;
    assign longitud    = longitud_q;
    assign ready_o     = ready_q;
    assign frame_ok_o  = ok_q;
    assign frame_err_o = err_q;

endmodule : uart_coord_receiver
`default_nettype wire
